mux_select_pipe: RTL and testbench
==================================

# mux_select_pipe

Parametrised, registered N-channel operand multiplexer with per-channel valid/ready handshakes and a registered output stage. It generalises the 16-bit 2:1 datapath mux to WIDTH bits and CHANNELS inputs. It adds a round-robin arbitration mode alongside explicit selection. It sits between producer stages (register file read ports, immediate/ALU-forwarding paths) and a consumer that may stall.

## Interface
Parameters:
- WIDTH, 16, data width of every channel and of the result
- CHANNELS, 4, number of input channels (≥ 2)
- SEL_WIDTH, 2, select width; must equal clog2(CHANNELS)

Ports:
- in_clk  input  1  single clock; all state updates on rising edge
- in_reset  input  1  synchronous, active-high reset
- in_data  input  CHANNELS*WIDTH  channel i at bits [i*WIDTH +: WIDTH]
- in_valid  input  CHANNELS  per-channel data valid
- ou_ready  output  CHANNELS  per-channel accept; at most one bit high
- in_select  input  SEL_WIDTH  channel index in explicit mode
- in_mode  input  1  0 = explicit select, 1 = round-robin
- ou_result  output  WIDTH  registered selected data
- ou_channel  output  SEL_WIDTH  index of channel that supplied ou_result
- ou_valid  output  1  ou_result holds untaken data
- in_ready  input  1  consumer accepts ou_result this cycle

## Operation
- Internal state: output register (ou_result, ou_channel, ou_valid) and round-robin pointer rr_ptr (SEL_WIDTH bits).
- can_accept = !in_reset && (!ou_valid || in_ready).
- Grant g, combinational:
  - Explicit mode: g = in_select. If in_select ≥ CHANNELS, no grant.
  - Round-robin mode: first i with in_valid[i] set, searching rr_ptr, rr_ptr+1, … with wrap modulo CHANNELS. If no in_valid bit is set, no grant.
- ou_ready[g] = can_accept when a grant exists; all other ou_ready bits are 0.
  - In explicit mode, ou_ready[g] does not depend on in_valid.
- Transfer: in_valid[g] && ou_ready[g]. On the next edge, ou_result ← channel g data, ou_channel ← g, ou_valid ← 1.
- Drain: ou_valid && in_ready.
  - Drain without transfer → ou_valid ← 0; ou_result and ou_channel keep their values.
  - Drain and transfer in the same cycle → new data loaded, ou_valid stays 1 (no bubble).
- Stall: ou_valid && !in_ready → all outputs held bit-stable; every ou_ready bit is 0.
- rr_ptr ← (g+1) mod CHANNELS only on a transfer while in_mode = 1. rr_ptr is unchanged in explicit mode.
- in_mode and in_select act combinationally each cycle. Changing either never alters an already-registered result.
- Reset:
  - ou_valid = 0, ou_result = 0, ou_channel = 0, rr_ptr = 0.
  - ou_ready = 0 in every cycle in_reset is high.
  - Reset asserted while stalled discards the held data.

## Timing
- Latency: 1 cycle from transfer edge to ou_valid/ou_result.
- Throughput: 1 transfer per cycle while in_ready stays high.
- Combinational paths:
  - in_ready → ou_ready.
  - in_valid/in_mode/in_select → ou_ready.
  - No combinational path from any input to ou_result, ou_channel or ou_valid.
- First transfer is possible in the cycle after in_reset deasserts.
- Round-robin fairness: with all channels continuously valid and in_ready = 1, grants cycle 0,1,…,CHANNELS-1,0,…; each channel is served once per CHANNELS cycles.

## Test plan
- Reset, then explicit mode; ch0 = 16'hAAAA, ch1 = 16'h5555, both valid, in_ready = 1.
  - in_select = 0 → next cycle ou_result = AAAA, ou_channel = 0.
  - in_select = 1 → ou_result = 5555, ou_channel = 1.
  - ou_ready one-hot on the selected channel.
- Stall: load 16'hFFF8, hold in_ready = 0 for 3 cycles while ch1 = 16'h001F is valid and selected.
  - ou_result stays FFF8, ou_ready = 0 throughout.
  - Raise in_ready → FFF8 drains and 001F loads on the same edge, no bubble.
- Round-robin with CHANNELS = 4: all valid, data = 16'h1111×(i+1), in_ready = 1.
  - Grants are 0,1,2,3,0.
  - Then only ch2 and ch0 valid with rr_ptr = 3 → grant 0, then 2.
- Explicit select of invalid channel 3 while ch0 is valid: no transfer, ou_valid falls after drain.
- Out-of-range select (CHANNELS = 3, in_select = 3): ou_ready = 0, no transfer.
- Reset while ou_valid = 1 and stalled: next cycle ou_valid = 0, ou_result = 0, ou_channel = 0, rr_ptr = 0, ou_ready = 0 during reset.

Source files
------------

// File: rtl/mux_select_pipe.sv
// mux_select_pipe: registered N-channel operand multiplexer.
// Each input channel has a valid/ready handshake. A single output register
// feeds a consumer that may stall. The grant comes either from an explicit
// channel index or from a round-robin search starting at rr_ptr.
module mux_select_pipe #(
    parameter int WIDTH     = 16,
    parameter int CHANNELS  = 4,
    parameter int SEL_WIDTH = 2
) (
    input  logic                      in_clk,
    input  logic                      in_reset,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       ou_ready,
    input  logic [SEL_WIDTH-1:0]      in_select,
    input  logic                      in_mode,
    output logic [WIDTH-1:0]          ou_result,
    output logic [SEL_WIDTH-1:0]      ou_channel,
    output logic                      ou_valid,
    input  logic                      in_ready
);

    logic [WIDTH-1:0]     result_q, result_d;
    logic [SEL_WIDTH-1:0] channel_q, channel_d;
    logic                 valid_q, valid_d;
    logic [SEL_WIDTH-1:0] rr_ptr_q, rr_ptr_d;

    logic                 can_accept;
    logic                 grant_ok;
    logic [SEL_WIDTH-1:0] grant_sel;
    logic [SEL_WIDTH-1:0] rr_cand;
    logic [WIDTH-1:0]     grant_data;
    logic                 transfer;

    // The output slot is free when empty, or when it is drained this cycle.
    always_comb begin
        can_accept = !in_reset && (!valid_q || in_ready);
    end

    // Grant selection: explicit index, or the first valid channel from rr_ptr.
    always_comb begin
        grant_ok  = 1'b0;
        grant_sel = '0;
        rr_cand   = '0;
        if (!in_mode) begin
            // Out-of-range indices (non power-of-two CHANNELS) get no grant.
            if (int'(in_select) < CHANNELS) begin
                grant_ok  = 1'b1;
                grant_sel = in_select;
            end
        end else begin
            // Walk offsets from far to near so the nearest valid channel wins.
            for (int k = CHANNELS - 1; k >= 0; k--) begin
                rr_cand = SEL_WIDTH'((int'(rr_ptr_q) + k) % CHANNELS);
                if (in_valid[rr_cand]) begin
                    grant_ok  = 1'b1;
                    grant_sel = rr_cand;
                end
            end
        end
    end

    // Ready is one-hot on the granted channel; in explicit mode it ignores in_valid.
    always_comb begin
        ou_ready   = '0;
        grant_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (SEL_WIDTH'(i) == grant_sel) begin
                ou_ready[i] = grant_ok && can_accept;
                grant_data  = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // A transfer needs both sides of the granted handshake.
    always_comb begin
        transfer = |(ou_ready & in_valid);
    end

    // Next state: load on transfer (also covers drain+load), clear valid on a bare drain.
    always_comb begin
        result_d  = result_q;
        channel_d = channel_q;
        valid_d   = valid_q;
        rr_ptr_d  = rr_ptr_q;
        if (transfer) begin
            result_d  = grant_data;
            channel_d = grant_sel;
            valid_d   = 1'b1;
            if (in_mode) begin
                rr_ptr_d = SEL_WIDTH'((int'(grant_sel) + 1) % CHANNELS);
            end
        end else if (valid_q && in_ready) begin
            valid_d = 1'b0;
        end
    end

    // State registers with synchronous reset; reset discards any held result.
    always_ff @(posedge in_clk) begin
        if (in_reset) begin
            result_q  <= '0;
            channel_q <= '0;
            valid_q   <= 1'b0;
            rr_ptr_q  <= '0;
        end else begin
            result_q  <= result_d;
            channel_q <= channel_d;
            valid_q   <= valid_d;
            rr_ptr_q  <= rr_ptr_d;
        end
    end

    // Outputs come straight from the register, so no input reaches them combinationally.
    always_comb begin
        ou_result  = result_q;
        ou_channel = channel_q;
        ou_valid   = valid_q;
    end

endmodule

// File: tb/tb_mux_select_pipe.sv
// Directed testbench for mux_select_pipe: a 4-channel instance for the main
// scenarios and a 3-channel instance for out-of-range select and wrap.
module tb_mux_select_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // 4-channel instance
    logic        a_reset  = 1'b1;
    logic [63:0] a_data   = '0;
    logic [3:0]  a_valid  = '0;
    logic [3:0]  a_ready_o;
    logic [1:0]  a_select = '0;
    logic        a_mode   = 1'b0;
    logic [15:0] a_result;
    logic [1:0]  a_channel;
    logic        a_valid_o;
    logic        a_ready  = 1'b0;

    // 3-channel instance
    logic        b_reset  = 1'b1;
    logic [47:0] b_data   = '0;
    logic [2:0]  b_valid  = '0;
    logic [2:0]  b_ready_o;
    logic [1:0]  b_select = '0;
    logic        b_mode   = 1'b0;
    logic [15:0] b_result;
    logic [1:0]  b_channel;
    logic        b_valid_o;
    logic        b_ready  = 1'b0;

    mux_select_pipe #(.WIDTH(16), .CHANNELS(4), .SEL_WIDTH(2)) dut_a (
        .in_clk     (clk),
        .in_reset   (a_reset),
        .in_data    (a_data),
        .in_valid   (a_valid),
        .ou_ready   (a_ready_o),
        .in_select  (a_select),
        .in_mode    (a_mode),
        .ou_result  (a_result),
        .ou_channel (a_channel),
        .ou_valid   (a_valid_o),
        .in_ready   (a_ready)
    );

    mux_select_pipe #(.WIDTH(16), .CHANNELS(3), .SEL_WIDTH(2)) dut_b (
        .in_clk     (clk),
        .in_reset   (b_reset),
        .in_data    (b_data),
        .in_valid   (b_valid),
        .ou_ready   (b_ready_o),
        .in_select  (b_select),
        .in_mode    (b_mode),
        .ou_result  (b_result),
        .ou_channel (b_channel),
        .ou_valid   (b_valid_o),
        .in_ready   (b_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_a(input string tag, input logic [15:0] res, input logic [1:0] ch,
                           input logic vld);
        check({tag, ".result"},  32'(a_result),  32'(res));
        check({tag, ".channel"}, 32'(a_channel), 32'(ch));
        check({tag, ".valid"},   32'(a_valid_o), 32'(vld));
    endtask

    task automatic check_b(input string tag, input logic [15:0] res, input logic [1:0] ch,
                           input logic vld);
        check({tag, ".result"},  32'(b_result),  32'(res));
        check({tag, ".channel"}, 32'(b_channel), 32'(ch));
        check({tag, ".valid"},   32'(b_valid_o), 32'(vld));
    endtask

    initial begin
        // Reset with live inputs: ready must stay low, state must clear.
        a_data  = {16'h0, 16'h0, 16'h5555, 16'hAAAA};
        a_valid = 4'b0011;
        a_ready = 1'b1;
        tick();
        check("rst_ready", 32'(a_ready_o), 'h0);
        tick();
        check_a("rst_state", 16'h0000, 2'd0, 1'b0);

        // Explicit select of channel 0, then channel 1 back to back.
        a_reset = 1'b0;
        #1;
        check("sel0_ready", 32'(a_ready_o), 'b0001);
        tick();
        check_a("sel0", 16'hAAAA, 2'd0, 1'b1);
        a_select = 2'd1;
        #1;
        check("sel1_ready", 32'(a_ready_o), 'b0010);
        tick();
        check_a("sel1", 16'h5555, 2'd1, 1'b1);

        // Load FFF8, then stall three cycles with ch1 = 001F offered.
        a_select = 2'd0;
        a_data   = {16'h0, 16'h0, 16'h001F, 16'hFFF8};
        tick();
        check_a("load_fff8", 16'hFFF8, 2'd0, 1'b1);
        a_ready  = 1'b0;
        a_select = 2'd1;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("stall_ready", 32'(a_ready_o), 'h0);
            tick();
            check_a("stall_hold", 16'hFFF8, 2'd0, 1'b1);
        end
        a_ready = 1'b1;
        #1;
        check("unstall_ready", 32'(a_ready_o), 'b0010);
        tick();
        check_a("drain_load", 16'h001F, 2'd1, 1'b1);

        // Explicit select of an invalid channel: ready still offered, no transfer.
        a_valid  = 4'b0001;
        a_select = 2'd3;
        #1;
        check("inv_sel_ready", 32'(a_ready_o), 'b1000);
        tick();
        check_a("inv_sel_drain", 16'h001F, 2'd1, 1'b0);

        // Round robin, all valid: grants 0,1,2,3,0,1,2 (leaves rr_ptr at 3).
        a_mode  = 1'b1;
        a_valid = 4'b1111;
        a_data  = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        #1;
        check("rr_first_ready", 32'(a_ready_o), 'b0001);
        tick();
        check_a("rr_g0", 16'h1111, 2'd0, 1'b1);
        tick();
        check_a("rr_g1", 16'h2222, 2'd1, 1'b1);
        tick();
        check_a("rr_g2", 16'h3333, 2'd2, 1'b1);
        tick();
        check_a("rr_g3", 16'h4444, 2'd3, 1'b1);
        tick();
        check_a("rr_g0_again", 16'h1111, 2'd0, 1'b1);
        tick();
        check_a("rr_g1_again", 16'h2222, 2'd1, 1'b1);
        tick();
        check_a("rr_g2_again", 16'h3333, 2'd2, 1'b1);

        // Only ch2 and ch0 valid with rr_ptr = 3: grant 0, then 2.
        a_valid = 4'b0101;
        #1;
        check("rr_skip_ready", 32'(a_ready_o), 'b0001);
        tick();
        check_a("rr_skip_g0", 16'h1111, 2'd0, 1'b1);
        tick();
        check_a("rr_skip_g2", 16'h3333, 2'd2, 1'b1);

        // rr_ptr = 3 now; ch0 only -> load, stall, then reset while stalled.
        a_valid = 4'b0001;
        tick();
        check_a("pre_rst_load", 16'h1111, 2'd0, 1'b1);
        a_ready = 1'b0;
        tick();
        check_a("pre_rst_stall", 16'h1111, 2'd0, 1'b1);
        a_reset = 1'b1;
        a_ready = 1'b1;
        #1;
        check("rst_stall_ready", 32'(a_ready_o), 'h0);
        tick();
        check_a("rst_stall_clear", 16'h0000, 2'd0, 1'b0);

        // rr_ptr must be back at 0: all valid grants channel 0 first.
        a_reset = 1'b0;
        a_valid = 4'b1111;
        #1;
        check("post_rst_rr_ready", 32'(a_ready_o), 'b0001);
        tick();
        check_a("post_rst_rr_g0", 16'h1111, 2'd0, 1'b1);

        // 3-channel instance: out-of-range select, then valid select, then wrap.
        b_data   = {16'h0C0C, 16'h0B0B, 16'h0A0A};
        b_valid  = 3'b111;
        b_select = 2'd3;
        b_ready  = 1'b1;
        tick();
        b_reset = 1'b0;
        #1;
        check("b_oor_ready", 32'(b_ready_o), 'h0);
        tick();
        check_b("b_oor_none", 16'h0000, 2'd0, 1'b0);
        b_select = 2'd2;
        #1;
        check("b_sel2_ready", 32'(b_ready_o), 'b100);
        tick();
        check_b("b_sel2", 16'h0C0C, 2'd2, 1'b1);
        b_mode = 1'b1;
        tick();
        check_b("b_rr_g0", 16'h0A0A, 2'd0, 1'b1);
        tick();
        check_b("b_rr_g1", 16'h0B0B, 2'd1, 1'b1);
        tick();
        check_b("b_rr_g2", 16'h0C0C, 2'd2, 1'b1);
        tick();
        check_b("b_rr_wrap", 16'h0A0A, 2'd0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
